// File: rtl/rs_pkg.sv
// Shared sizing, state encoding and helpers for the Reed-Solomon decoder control path.
package rs_pkg;

  localparam int N      = 204;
  localparam int T      = 8;
  localparam int DEG_W  = 4;
  localparam int ROOT_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    SYND,
    SCHK,
    KES,
    ZCALC,
    CHIEN,
    DONE
  } state_t;

  // Bits needed to hold every value 0..max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/rs_wait_timer.sv
// Shared wait/latency counter: restarts on clear, counts while enabled, saturates at all-ones.
module rs_wait_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/rs_decoder_controller.sv
// Sequences syndrome, key-equation, z-calculation and Chien/Forney stages for one RS codeword.
module rs_decoder_controller #(
  parameter int N         = rs_pkg::N,
  parameter int T         = rs_pkg::T,
  parameter int Z_LATENCY = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      In_Valid,
  input  logic                      In_Sof,
  output logic                      In_Ready,
  output logic                      Synd_Clear,
  output logic                      Synd_En,
  input  logic                      Synd_Zero,
  output logic                      Kes_Start,
  input  logic                      Kes_Done,
  input  logic [rs_pkg::DEG_W-1:0]  Kes_Degree,
  output logic                      Z_Load,
  output logic                      Chien_Start,
  input  logic                      Chien_Done,
  input  logic [rs_pkg::ROOT_W-1:0] Chien_Roots,
  output logic                      Cw_Done,
  output logic                      Cw_Uncorrectable,
  output logic [rs_pkg::ROOT_W-1:0] Cw_Err_Count,
  output logic                      Busy
);

  import rs_pkg::*;

  localparam int CNT_W  = cnt_width(N);
  localparam int WAIT_W = cnt_width((TIMEOUT > Z_LATENCY) ? TIMEOUT : Z_LATENCY);

  state_t              state;
  state_t              next;
  logic [CNT_W-1:0]    byte_cnt;
  logic [DEG_W-1:0]    deg_q;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                sof_seen;
  logic                frame_last;
  logic                deg_over;
  logic                wait_expired;
  logic                z_last;
  logic                roots_mismatch;
  logic                res_load;
  logic                res_unc;
  logic [ROOT_W-1:0]   res_cnt;

  assign sof_seen       = In_Valid && In_Sof && Reset;
  // A restarting SOF counts as byte 1, so it ends the frame only when N is 1.
  assign frame_last     = In_Sof ? (N == 1) : (byte_cnt == CNT_W'(N - 1));
  assign deg_over       = int'(Kes_Degree) > T;
  // Wait counter is 0 in the first cycle of KES/CHIEN, so TIMEOUT cycles elapse before giving up.
  assign wait_expired   = (wait_cnt == WAIT_W'(TIMEOUT - 1));
  assign z_last         = (wait_cnt == WAIT_W'(Z_LATENCY - 1));
  assign roots_mismatch = (Chien_Roots != deg_q);

  rs_wait_timer #(.W(WAIT_W)) u_wait_timer (
    .clk   (Clk),
    .rst_n (Reset),
    .clear (next != state),
    .en    ((state == KES) || (state == ZCALC) || (state == CHIEN)),
    .count (wait_cnt)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
    end else begin
      state <= next;
    end
  end

  always_comb begin
    next     = state;
    res_load = 1'b0;
    res_unc  = 1'b0;
    res_cnt  = '0;
    case (state)
      IDLE: begin
        if (In_Valid && In_Sof) next = (N == 1) ? SCHK : SYND;
      end
      SYND: begin
        if (In_Valid && frame_last) next = SCHK;
      end
      SCHK: begin
        if (Synd_Zero) begin
          next     = DONE;
          res_load = 1'b1;
        end else begin
          next = KES;
        end
      end
      KES: begin
        if (Kes_Done) begin
          if (deg_over) begin
            next     = DONE;
            res_load = 1'b1;
            res_unc  = 1'b1;
          end else begin
            next = ZCALC;
          end
        end else if (wait_expired) begin
          next     = DONE;
          res_load = 1'b1;
          res_unc  = 1'b1;
        end
      end
      ZCALC: begin
        if (z_last) next = CHIEN;
      end
      CHIEN: begin
        if (Chien_Done) begin
          next     = DONE;
          res_load = 1'b1;
          res_unc  = roots_mismatch;
          res_cnt  = roots_mismatch ? '0 : Chien_Roots;
        end else if (wait_expired) begin
          next     = DONE;
          res_load = 1'b1;
          res_unc  = 1'b1;
        end
      end
      DONE:    next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_comb begin
    In_Ready    = (state == IDLE) || (state == SYND);
    Busy        = (state != IDLE);
    Cw_Done     = (state == DONE);
    Synd_Clear  = 1'b0;
    Synd_En     = 1'b0;
    Kes_Start   = 1'b0;
    Z_Load      = 1'b0;
    Chien_Start = 1'b0;
    case (state)
      IDLE: begin
        Synd_Clear = sof_seen;
        Synd_En    = sof_seen;
      end
      SYND: begin
        Synd_En    = In_Valid;
        Synd_Clear = In_Valid && In_Sof;
      end
      SCHK:    Kes_Start   = !Synd_Zero;
      KES:     Z_Load      = Kes_Done && !deg_over;
      ZCALC:   Chien_Start = z_last;
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      byte_cnt         <= '0;
      deg_q            <= '0;
      Cw_Uncorrectable <= 1'b0;
      Cw_Err_Count     <= '0;
    end else begin
      if (Synd_Clear) begin
        byte_cnt <= CNT_W'(1);
      end else if (Synd_En) begin
        byte_cnt <= byte_cnt + CNT_W'(1);
      end
      if (Z_Load) deg_q <= Kes_Degree;
      if (res_load) begin
        Cw_Uncorrectable <= res_unc;
        Cw_Err_Count     <= res_cnt;
      end
    end
  end

endmodule

// File: tb/tb_rs_decoder_controller.sv
// Randomized bench for rs_decoder_controller against a timeline model of one codeword's journey.
module tb_rs_decoder_controller;

  localparam int N     = 204;
  localparam int T     = 8;
  localparam int Z_LAT = 4;
  localparam int TMO   = 255;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       In_Valid, In_Sof, In_Ready;
  logic       Synd_Clear, Synd_En, Synd_Zero;
  logic       Kes_Start, Kes_Done;
  logic [3:0] Kes_Degree;
  logic       Z_Load, Chien_Start, Chien_Done;
  logic [3:0] Chien_Roots;
  logic       Cw_Done, Cw_Uncorrectable;
  logic [3:0] Cw_Err_Count;
  logic       Busy;

  rs_decoder_controller #(.N(N), .T(T), .Z_LATENCY(Z_LAT), .TIMEOUT(TMO)) dut (
    .Clk(Clk), .Reset(Reset), .In_Valid(In_Valid), .In_Sof(In_Sof), .In_Ready(In_Ready),
    .Synd_Clear(Synd_Clear), .Synd_En(Synd_En), .Synd_Zero(Synd_Zero),
    .Kes_Start(Kes_Start), .Kes_Done(Kes_Done), .Kes_Degree(Kes_Degree),
    .Z_Load(Z_Load), .Chien_Start(Chien_Start), .Chien_Done(Chien_Done),
    .Chien_Roots(Chien_Roots), .Cw_Done(Cw_Done), .Cw_Uncorrectable(Cw_Uncorrectable),
    .Cw_Err_Count(Cw_Err_Count), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int n_clear = 0, n_en = 0, n_kes = 0, n_zl = 0, n_cs = 0, n_done = 0;
  int t_kes = 0, t_zl = 0, t_cs = 0, t_done = 0, done_unc = 0, done_cnt = 0;

  always @(negedge Clk) begin
    if (Synd_Clear)  n_clear <= n_clear + 1;
    if (Synd_En)     n_en    <= n_en + 1;
    if (Kes_Start)   begin n_kes <= n_kes + 1; t_kes <= cyc; end
    if (Z_Load)      begin n_zl  <= n_zl + 1;  t_zl  <= cyc; end
    if (Chien_Start) begin n_cs  <= n_cs + 1;  t_cs  <= cyc; end
    if (Cw_Done) begin
      n_done   <= n_done + 1;
      t_done   <= cyc;
      done_unc <= int'(Cw_Uncorrectable);
      done_cnt <= int'(Cw_Err_Count);
    end
  end

  int n_compared = 0, n_mismatched = 0;

  task automatic check_eq(input string tag, input int actual, input int expected);
    n_compared++;
    if (actual != expected) begin
      n_mismatched++;
      $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Event times are relative to the cycle carrying the codeword's last byte.
  typedef struct {
    int done_t; int unc; int cnt;
    int kes; int zl; int zl_t; int cs; int cs_t;
  } pred_t;

  function automatic pred_t predict(input int sz, input int d, input int deg,
                                    input int roots, input int c);
    pred_t p;
    int ce;
    p = '{default: 0};
    if (sz != 0) begin
      p.done_t = 2;
      return p;
    end
    p.kes = 1;
    if (d >= TMO) begin
      p.done_t = 2 + TMO;
      p.unc    = 1;
      return p;
    end
    if (deg > T) begin
      p.done_t = 3 + d;
      p.unc    = 1;
      return p;
    end
    p.zl   = 1;
    p.zl_t = 2 + d;
    p.cs   = 1;
    p.cs_t = p.zl_t + Z_LAT;
    ce     = p.cs_t + 1;
    if (c >= TMO) begin
      p.done_t = ce + TMO;
      p.unc    = 1;
    end else begin
      p.done_t = ce + c + 1;
      p.unc    = (roots != deg) ? 1 : 0;
      p.cnt    = (p.unc != 0) ? 0 : roots;
    end
    return p;
  endfunction

  task automatic run_frame(input string name, input int sz, input int d, input int deg,
                           input int roots, input int c, input int restart_at,
                           input int rst_at, input bit noisy);
    pred_t p;
    int need, sent, last, ce, end_cyc, kes_hi, chien_hi, exp_n;
    int b_clear, b_en, b_kes, b_zl, b_cs, b_done;
    bit v, in_kes, in_chien;
    p        = predict(sz, d, deg, roots, c);
    need     = (restart_at > 0) ? restart_at + N : N;
    b_clear  = n_clear; b_en = n_en; b_kes = n_kes;
    b_zl     = n_zl;    b_cs = n_cs; b_done = n_done;
    repeat ($urandom_range(0, 3)) begin
      @(posedge Clk); #1;
      In_Valid = noisy && ($urandom_range(0, 1) != 0);
      In_Sof   = 1'b0;
    end
    sent = 0;
    last = 0;
    while (sent < need) begin
      @(posedge Clk); #1;
      v           = (sent == 0) || ($urandom_range(0, 3) != 0);
      In_Valid    = v;
      In_Sof      = v ? ((sent == 0) || (sent == restart_at)) : ($urandom_range(0, 1) != 0);
      Synd_Zero   = ($urandom_range(0, 1) != 0);
      Kes_Done    = noisy && ($urandom_range(0, 7) == 0);
      Chien_Done  = noisy && ($urandom_range(0, 7) == 0);
      Kes_Degree  = 4'($urandom_range(0, 15));
      Chien_Roots = 4'($urandom_range(0, 15));
      if (v) begin
        sent++;
        last = cyc;
      end
    end
    ce       = last + p.cs_t + 1;
    kes_hi   = last + 2 + ((d < TMO) ? d : TMO - 1);
    chien_hi = ce + ((c < TMO) ? c : TMO - 1);
    end_cyc  = last + p.done_t + 3;
    while (cyc < end_cyc) begin
      @(posedge Clk); #1;
      if (!Reset) Reset = 1'b1;
      in_kes      = (sz == 0) && (cyc >= last + 2) && (cyc <= kes_hi);
      in_chien    = (p.cs != 0) && (cyc >= ce) && (cyc <= chien_hi);
      In_Valid    = noisy && (cyc < last + p.done_t) && ($urandom_range(0, 1) != 0);
      In_Sof      = ($urandom_range(0, 1) != 0);
      Synd_Zero   = (cyc == last + 1) ? (sz != 0) : ($urandom_range(0, 1) != 0);
      Kes_Done    = ((sz == 0) && (cyc == last + 2 + d)) ||
                    (noisy && !in_kes && ($urandom_range(0, 3) == 0));
      Kes_Degree  = (cyc == last + 2 + d) ? 4'(deg) : 4'($urandom_range(0, 15));
      Chien_Done  = ((p.cs != 0) && (cyc == ce + c)) ||
                    (noisy && !in_chien && ($urandom_range(0, 3) == 0));
      Chien_Roots = (cyc == ce + c) ? 4'(roots) : 4'($urandom_range(0, 15));
      if ((rst_at >= 0) && (cyc == ce + rst_at)) begin
        Reset = 1'b0;
        #1;
        check_eq({name, " rst_in_ready"}, int'(In_Ready), 1);
        check_eq({name, " rst_busy"}, int'(Busy), 0);
        check_eq({name, " rst_unc"}, int'(Cw_Uncorrectable), 0);
        check_eq({name, " rst_err_count"}, int'(Cw_Err_Count), 0);
      end
    end
    In_Valid   = 1'b0;
    In_Sof     = 1'b0;
    Kes_Done   = 1'b0;
    Chien_Done = 1'b0;
    exp_n = (rst_at >= 0) ? 0 : 1;
    check_eq({name, " cw_done_count"}, n_done - b_done, exp_n);
    if (exp_n == 1) begin
      check_eq({name, " cw_done_time"}, t_done - last, p.done_t);
      check_eq({name, " cw_unc"}, done_unc, p.unc);
      check_eq({name, " cw_err_count"}, done_cnt, p.cnt);
    end
    check_eq({name, " synd_clear_count"}, n_clear - b_clear, (restart_at > 0) ? 2 : 1);
    check_eq({name, " synd_en_count"}, n_en - b_en, need);
    check_eq({name, " kes_start_count"}, n_kes - b_kes, p.kes);
    if (p.kes != 0) check_eq({name, " kes_start_time"}, t_kes - last, 1);
    check_eq({name, " z_load_count"}, n_zl - b_zl, p.zl);
    if (p.zl != 0) check_eq({name, " z_load_time"}, t_zl - last, p.zl_t);
    check_eq({name, " chien_start_count"}, n_cs - b_cs, p.cs);
    if (p.cs != 0) check_eq({name, " chien_start_time"}, t_cs - last, p.cs_t);
    check_eq({name, " hold_unc"}, int'(Cw_Uncorrectable), (exp_n == 1) ? p.unc : 0);
    check_eq({name, " hold_err_count"}, int'(Cw_Err_Count), (exp_n == 1) ? p.cnt : 0);
    check_eq({name, " idle_busy"}, int'(Busy), 0);
    check_eq({name, " idle_in_ready"}, int'(In_Ready), 1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int sz, d, deg, roots, c, rs;
    Reset       = 1'b0;
    In_Valid    = 1'b1;
    In_Sof      = 1'b1;
    Synd_Zero   = 1'b0;
    Kes_Done    = 1'b0;
    Kes_Degree  = '0;
    Chien_Done  = 1'b0;
    Chien_Roots = '0;
    repeat (2) @(posedge Clk);
    #1;
    check_eq("reset in_ready", int'(In_Ready), 1);
    check_eq("reset busy", int'(Busy), 0);
    check_eq("reset synd_clear", int'(Synd_Clear), 0);
    check_eq("reset synd_en", int'(Synd_En), 0);
    check_eq("reset cw_done", int'(Cw_Done), 0);
    check_eq("reset unc", int'(Cw_Uncorrectable), 0);
    check_eq("reset err_count", int'(Cw_Err_Count), 0);
    In_Valid = 1'b0;
    In_Sof   = 1'b0;
    Reset    = 1'b1;
    @(posedge Clk); #1;

    run_frame("clean",       1, 0,        0, 0, 0,       0,  -1, 1'b0);
    run_frame("kes20",       0, 20,       3, 3, 10,      0,  -1, 1'b1);
    run_frame("deg9",        0, 5,        9, 9, 0,       0,  -1, 1'b1);
    run_frame("deg8",        0, 0,        8, 8, 0,       0,  -1, 1'b1);
    run_frame("roots_ne",    0, 7,        6, 5, 12,      0,  -1, 1'b1);
    run_frame("kes_tmo",     0, 400,      2, 2, 0,       0,  -1, 1'b1);
    run_frame("kes_last",    0, TMO - 1,  2, 2, 3,       0,  -1, 1'b1);
    run_frame("chien_last",  0, 1,        5, 5, TMO - 1, 0,  -1, 1'b1);
    run_frame("chien_tmo",   0, 1,        5, 5, 400,     0,  -1, 1'b1);
    run_frame("reset_chien", 0, 3,        4, 4, 50,      0,  10, 1'b0);
    run_frame("restart",     1, 0,        0, 0, 0,       100, -1, 1'b1);
    run_frame("restart_kes", 0, 2,        1, 1, 2,       37, -1, 1'b1);

    for (int i = 0; i < 16; i++) begin
      sz    = ($urandom_range(0, 3) == 0) ? 1 : 0;
      rs    = $urandom_range(0, 9);
      d     = (rs == 0) ? TMO - 1 : (rs == 1) ? TMO + $urandom_range(0, 40) : $urandom_range(0, 30);
      deg   = $urandom_range(0, 15);
      roots = ($urandom_range(0, 1) != 0) ? deg : $urandom_range(0, 15);
      rs    = $urandom_range(0, 9);
      c     = (rs == 0) ? TMO - 1 : (rs == 1) ? TMO + $urandom_range(0, 40) : $urandom_range(0, 30);
      run_frame("random", sz, d, deg, roots, c,
                ($urandom_range(0, 4) == 0) ? $urandom_range(1, N - 1) : 0, -1, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
